// File: rtl/bldc_pkg.sv
// Shared types and lookup tables for the BLDC commutator.
// Holds the FSM state enum, hall-to-step tables and the step-to-drive table.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_STOP        = 2'd0,
    ST_OPEN_LOOP   = 2'd1,
    ST_CLOSED_LOOP = 2'd2,
    ST_FAULT       = 2'd3
  } bldc_state_e;

  // Indexed by raw hall code; codes 0 and 7 are invalid and never looked up.
  localparam logic [2:0] HALL_CW_TABLE  [0:7] = '{3'd0, 3'd4, 3'd0, 3'd5, 3'd2, 3'd3, 3'd1, 3'd0};
  localparam logic [2:0] HALL_CCW_TABLE [0:7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd0, 3'd4, 3'd0};

  // {high_sel[T,S,R], low_sel[T,S,R]} per commutation step.
  localparam logic [5:0] STEP_DRIVE_TABLE [0:7] = '{
    6'b001_010, 6'b001_100, 6'b010_100,
    6'b010_001, 6'b100_001, 6'b100_010,
    6'b000_000, 6'b000_000
  };

  function automatic logic hall_is_valid(input logic [2:0] hall);
    return (hall != 3'd0) && (hall != 3'd7);
  endfunction

  function automatic logic [2:0] hall_to_step(input logic [2:0] hall, input logic cw);
    return cw ? HALL_CW_TABLE[hall] : HALL_CCW_TABLE[hall];
  endfunction

  function automatic logic [2:0] step_advance(input logic [2:0] step, input logic cw);
    if (cw) return (step == 3'd5) ? 3'd0 : step + 3'd1;
    else    return (step == 3'd0) ? 3'd5 : step - 3'd1;
  endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// Control, sensor and gate-drive bundle of the BLDC commutator.
interface bldc_commutator_if #(
  parameter int PWM_BITS = 8
);
  logic                tick_en;
  logic                enable;
  logic                dir;
  logic [PWM_BITS-1:0] duty;
  logic [2:0]          hall;
  logic [2:0]          hin;
  logic [2:0]          lin_n;
  logic [2:0]          comm_state;
  logic                running;
  logic [7:0]          speed_cnt;
  logic                fault;

  modport master (
    output tick_en, enable, dir, duty, hall,
    input  hin, lin_n, comm_state, running, speed_cnt, fault
  );

  modport slave (
    input  tick_en, enable, dir, duty, hall,
    output hin, lin_n, comm_state, running, speed_cnt, fault
  );
endinterface

// File: rtl/bldc_deadtime.sv
// Blanks the gate drives for DEAD_CYCLES clocks on every change of target
// pattern; switching to all-off is immediate. Low side is PWM gated.
module bldc_deadtime #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] pattern,
  input  logic       pwm_on,
  output logic [2:0] hin,
  output logic [2:0] lin_n
);
  localparam int CNT_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic [5:0]       pattern_prev_reg;
  logic [CNT_W-1:0] dead_cnt_reg;
  logic [CNT_W-1:0] dead_cnt_next;
  logic             pattern_changed;
  logic             blanked;
  logic [5:0]       drive;

  assign pattern_changed = (pattern != pattern_prev_reg);

  // The change cycle itself is the first blanked cycle, so reload with one less.
  always_comb begin
    dead_cnt_next = dead_cnt_reg;
    if (pattern == 6'd0)
      dead_cnt_next = '0;
    else if (pattern_changed)
      dead_cnt_next = RELOAD;
    else if (dead_cnt_reg != '0)
      dead_cnt_next = dead_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_prev_reg <= '0;
      dead_cnt_reg     <= '0;
    end else begin
      pattern_prev_reg <= pattern;
      dead_cnt_reg     <= dead_cnt_next;
    end
  end

  assign blanked = (DEAD_CYCLES > 0) && (pattern_changed || (dead_cnt_reg != '0));
  assign drive   = blanked ? 6'd0 : pattern;
  assign hin     = drive[5:3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_low_gate
      assign lin_n[gi] = ~(drive[gi] & pwm_on);
    end
  endgenerate

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: open-loop start-up, hall-driven closed loop,
// speed qualification, invalid-hall fault and dead-time protected PWM drive.
module bldc_commutator #(
  parameter int PWM_BITS       = 8,
  parameter int DEAD_CYCLES    = 4,
  parameter int OPEN_PERIOD    = 110,
  parameter int SPEED_WINDOW   = 2024,
  parameter int MIN_EDGES      = 2,
  parameter int BAD_HALL_TICKS = 8
) (
  input logic               clk,
  input logic               rst_n,
  bldc_commutator_if.slave  bus
);
  import bldc_pkg::*;

  localparam int STEP_W = (OPEN_PERIOD < 1) ? 1 : $clog2(OPEN_PERIOD + 1);
  localparam int WIN_W  = (SPEED_WINDOW < 2) ? 1 : $clog2(SPEED_WINDOW);
  localparam int BAD_W  = (BAD_HALL_TICKS < 2) ? 1 : $clog2(BAD_HALL_TICKS);

  bldc_state_e         state_reg, state_next;
  logic [2:0]          comm_reg, comm_next;
  logic [STEP_W-1:0]   step_cnt_reg, step_cnt_next;
  logic [BAD_W-1:0]    bad_cnt_reg, bad_cnt_next;

  logic [2:0]          hall_meta_reg, hall_sync_reg, hall_prev_reg;
  logic [7:0]          edge_cnt_reg, edge_cnt_inc;
  logic [WIN_W-1:0]    win_cnt_reg;
  logic [7:0]          speed_cnt_reg;
  logic                running_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;

  logic                hall_edge;
  logic                pwm_on;
  logic [5:0]          target_pattern;
  logic [2:0]          hin_w, lin_n_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_meta_reg <= '0;
      hall_sync_reg <= '0;
      pwm_cnt_reg   <= '0;
    end else begin
      hall_meta_reg <= bus.hall;
      hall_sync_reg <= hall_meta_reg;
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
    end
  end

  // Speed measurement: edges counted per tick, published at window end.
  assign hall_edge    = (hall_sync_reg != hall_prev_reg);
  assign edge_cnt_inc = (hall_edge && (edge_cnt_reg != 8'hFF)) ? edge_cnt_reg + 8'd1 : edge_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_prev_reg <= '0;
      edge_cnt_reg  <= '0;
      win_cnt_reg   <= '0;
      speed_cnt_reg <= '0;
      running_reg   <= 1'b0;
    end else if (bus.tick_en) begin
      hall_prev_reg <= hall_sync_reg;
      if (win_cnt_reg == WIN_W'(SPEED_WINDOW - 1)) begin
        win_cnt_reg   <= '0;
        edge_cnt_reg  <= '0;
        speed_cnt_reg <= edge_cnt_inc;
        running_reg   <= (edge_cnt_inc >= 8'(MIN_EDGES));
      end else begin
        win_cnt_reg  <= win_cnt_reg + 1'b1;
        edge_cnt_reg <= edge_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_STOP;
      comm_reg     <= '0;
      step_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      comm_reg     <= comm_next;
      step_cnt_reg <= step_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    comm_next     = comm_reg;
    step_cnt_next = step_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (!bus.enable) begin
      state_next    = ST_STOP;
      step_cnt_next = '0;
      bad_cnt_next  = '0;
    end else begin
      case (state_reg)
        ST_STOP: begin
          state_next    = ST_OPEN_LOOP;
          comm_next     = 3'd0;
          step_cnt_next = '0;
        end
        ST_OPEN_LOOP: begin
          if (running_reg) begin
            state_next   = ST_CLOSED_LOOP;
            bad_cnt_next = '0;
          end else if (bus.tick_en) begin
            if (step_cnt_reg == STEP_W'(OPEN_PERIOD)) begin
              step_cnt_next = '0;
              comm_next     = step_advance(comm_reg, bus.dir);
            end else begin
              step_cnt_next = step_cnt_reg + 1'b1;
            end
          end
        end
        ST_CLOSED_LOOP: begin
          // Losing speed qualification falls back to forced stepping from the current step.
          if (!running_reg) begin
            state_next    = ST_OPEN_LOOP;
            step_cnt_next = '0;
          end else if (bus.tick_en) begin
            if (hall_is_valid(hall_sync_reg)) begin
              bad_cnt_next = '0;
              comm_next    = hall_to_step(hall_sync_reg, bus.dir);
            end else if (bad_cnt_reg == BAD_W'(BAD_HALL_TICKS - 1)) begin
              state_next = ST_FAULT;
            end else begin
              bad_cnt_next = bad_cnt_reg + 1'b1;
            end
          end
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_STOP;
      endcase
    end
  end

  assign target_pattern = ((state_reg == ST_OPEN_LOOP) || (state_reg == ST_CLOSED_LOOP))
                          ? STEP_DRIVE_TABLE[comm_reg] : 6'd0;
  assign pwm_on = (pwm_cnt_reg < bus.duty);

  bldc_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk     (clk),
    .rst_n   (rst_n),
    .pattern (target_pattern),
    .pwm_on  (pwm_on),
    .hin     (hin_w),
    .lin_n   (lin_n_w)
  );

  assign bus.hin        = hin_w;
  assign bus.lin_n      = lin_n_w;
  assign bus.comm_state = comm_reg;
  assign bus.running    = running_reg;
  assign bus.speed_cnt  = speed_cnt_reg;
  assign bus.fault      = (state_reg == ST_FAULT);

endmodule

// File: doc/bldc_commutator.md
BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 Parameter PWM_BITS, default 8: duty and PWM counter width.
REQ-002 Parameter DEAD_CYCLES, default 4: clk cycles of all-off between drive patterns (0 allowed).
REQ-003 Parameter OPEN_PERIOD, default 110: tick_en strobes per forced-commutation step minus one.
REQ-004 Parameter SPEED_WINDOW, default 2024: tick_en strobes per speed-measurement window.
REQ-005 Parameter MIN_EDGES, default 2: hall edges per window needed to declare running.
REQ-006 Parameter BAD_HALL_TICKS, default 8: consecutive invalid-hall ticks that trigger fault.
REQ-007 clk  in  1  single system clock; all logic on posedge clk.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 tick_en  in  1  one-clk control-rate strobe.
REQ-010 enable  in  1  1 = drive motor, 0 = stop and clear fault.
REQ-011 dir  in  1  1 = CW, 0 = CCW.
REQ-012 duty  in  PWM_BITS  low-side on-time, in PWM counts.
REQ-013 hall  in  3  raw hall sensors, asynchronous.
REQ-014 hin  out  3  high-side gate drives {T,S,R}, active-high.
REQ-015 lin_n  out  3  low-side gate drives {T,S,R}, active-low.
REQ-016 comm_state  out  3  current commutation step 0..5.
REQ-017 running  out  1  closed-loop speed qualified.
REQ-018 speed_cnt  out  8  hall edges in last complete window, saturating at 255.
REQ-019 fault  out  1  hall fault latched.

Function
REQ-020 hall SHALL pass a 2-FF synchroniser; all hall logic uses the synchronised value.
REQ-021 FSM states STOP, OPEN_LOOP, CLOSED_LOOP, FAULT; enable=0 forces STOP on the next clk from any state.
REQ-022 STOP -> OPEN_LOOP when enable=1: comm_state=0, step counter=0.
REQ-023 OPEN_LOOP: step counter increments per tick_en; at OPEN_PERIOD it clears and comm_state steps +1 mod 6 (dir=1) or -1 mod 6 (dir=0).
REQ-024 OPEN_LOOP -> CLOSED_LOOP when running rises; CLOSED_LOOP -> OPEN_LOOP when running falls, holding comm_state.
REQ-025 CLOSED_LOOP comm_state from hall: CW 1/2/3/4/5/6 -> 4/0/5/2/3/1; CCW 1/2/3/4/5/6 -> 1/3/2/5/0/4; evaluated per tick_en.
REQ-026 Hall code 0 or 7 in CLOSED_LOOP holds comm_state; BAD_HALL_TICKS consecutive such ticks -> FAULT, fault=1; FAULT exits only via enable=0.
REQ-027 Speed: each tick_en with hall different from the previous sampled hall increments an 8-bit saturating edge counter; on the tick ending the window, speed_cnt <= count (including that tick's edge), running <= (count >= MIN_EDGES), and the count clears.
REQ-028 Drive pattern per comm_state (high/low phase): 0 R/S, 1 R/T, 2 S/T, 3 S/R, 4 T/R, 5 T/S; STOP and FAULT pattern is all off.
REQ-029 PWM counter is free-running on clk, PWM_BITS wide, wrapping; pwm_on = counter < duty. duty=0 means never on; the maximum duty gives 2^PWM_BITS-1 on cycles per period.
REQ-030 Only the low side is PWM gated: lin_n[i] = ~(low_sel[i] & pwm_on); hin is not gated.
REQ-031 On any target-pattern change, hin=0 and lin_n=3'b111 for DEAD_CYCLES clk, then the new pattern applies; a further change during dead time restarts the count and uses the latest target.
REQ-032 A change to the all-off pattern (STOP/FAULT) applies immediately with no dead time.
REQ-033 A dir change in CLOSED_LOOP takes effect on the next tick_en, with dead time.

Reset
REQ-034 rst_n=0 asynchronously: FSM=STOP, hin=0, lin_n=3'b111, comm_state=0, running=0, speed_cnt=0, fault=0, and all counters and synchroniser flops cleared.
REQ-035 After rst_n deasserts, outputs stay off until enable=1 is sampled.

Structure
REQ-036 Package bldc_pkg SHALL hold the FSM state enum, CW/CCW hall-to-step tables and the step-to-phase drive table.
REQ-037 Dead-time insertion SHALL be sub-module bldc_deadtime (parameter DEAD_CYCLES, 6-bit pattern in, gated outputs).

Verification
REQ-038 Reset mid-drive (state 3, pattern S/R): hin=0 and lin_n=111 within the same cycle; state and counters read 0.
REQ-039 enable=1, dir=1, hall static, tick_en every cycle: comm_state 0->1 after 111 ticks; with dir=0, 0->5.
REQ-040 Hall sequence 2,6,4,5,1,3 at 1 edge per 100 ticks: running=1 at window end; comm_state follows 0,1,2,3,4,5; CCW table is checked similarly.
REQ-041 Pattern change with DEAD_CYCLES=4: exactly 4 clk of hin=0 and lin_n=111; a second change on cycle 2 extends the off time to 2+4 cycles.
REQ-042 duty=0 -> lin_n all 1; duty=255 -> 255 of 256 cycles low on the selected phase; duty=64 -> 64 of 256.
REQ-043 hall=7 held for 8 ticks in CLOSED_LOOP -> fault=1 and outputs off; enable=0 then 1 -> fault=0 and OPEN_LOOP.
